// File: rtl/control_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, ALU selects,
// sequencer state codes and the decoded instruction class.
package control_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SHR  = 4'd3;
    localparam logic [3:0] ALU_SHL  = 4'd4;
    localparam logic [3:0] ALU_ROR  = 4'd5;
    localparam logic [3:0] ALU_ROL  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_NEG  = 4'd9;
    localparam logic [3:0] ALU_NOT  = 4'd10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Instruction register decode: class, ALU select and one-hot register selects.
// Purely combinational, zero latency.
// No flow control; outputs follow ir directly.
module instr_decoder
    import control_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16,
    parameter int REG_SEL_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] ir,
    output instr_class_t          cls,
    output logic [3:0]            alu_op,
    output logic [NUM_REGS-1:0]   ra_oh,
    output logic [NUM_REGS-1:0]   rb_oh,
    output logic [NUM_REGS-1:0]   rc_oh
);

    localparam int OPW = 5;
    localparam int LOW = DATA_WIDTH - OPW - 3 * REG_SEL_WIDTH;

    logic [OPW-1:0]           opcode;
    logic [REG_SEL_WIDTH-1:0] ra;
    logic [REG_SEL_WIDTH-1:0] rb;
    logic [REG_SEL_WIDTH-1:0] rc;
    logic                     unused_ir_low;
    instr_class_t             base_cls;

    assign opcode = ir[DATA_WIDTH-1 -: OPW];
    assign ra     = ir[DATA_WIDTH-1-OPW -: REG_SEL_WIDTH];
    assign rb     = ir[DATA_WIDTH-1-OPW-REG_SEL_WIDTH -: REG_SEL_WIDTH];
    assign rc     = ir[DATA_WIDTH-1-OPW-2*REG_SEL_WIDTH -: REG_SEL_WIDTH];
    // Low bits only matter to the datapath as the immediate.
    assign unused_ir_low = ^ir[LOW-1:0];

    function automatic logic reg_ok(input logic [REG_SEL_WIDTH-1:0] r);
        return 32'(r) < NUM_REGS;
    endfunction

    always_comb begin
        base_cls = CLS_ILLEGAL;
        alu_op   = ALU_NONE;
        case (opcode)
            OP_ADD:  begin base_cls = CLS_R;     alu_op = ALU_ADD; end
            OP_SUB:  begin base_cls = CLS_R;     alu_op = ALU_SUB; end
            OP_SHR:  begin base_cls = CLS_R;     alu_op = ALU_SHR; end
            OP_SHL:  begin base_cls = CLS_R;     alu_op = ALU_SHL; end
            OP_ROR:  begin base_cls = CLS_R;     alu_op = ALU_ROR; end
            OP_ROL:  begin base_cls = CLS_R;     alu_op = ALU_ROL; end
            OP_AND:  begin base_cls = CLS_R;     alu_op = ALU_AND; end
            OP_OR:   begin base_cls = CLS_R;     alu_op = ALU_OR;  end
            OP_ADDI: begin base_cls = CLS_I;     alu_op = ALU_ADD; end
            OP_ANDI: begin base_cls = CLS_I;     alu_op = ALU_AND; end
            OP_ORI:  begin base_cls = CLS_I;     alu_op = ALU_OR;  end
            OP_NEG:  begin base_cls = CLS_UNARY; alu_op = ALU_NEG; end
            OP_NOT:  begin base_cls = CLS_UNARY; alu_op = ALU_NOT; end
            OP_NOP:  base_cls = CLS_NOP;
            OP_HALT: base_cls = CLS_HALT;
            default: ;
        endcase

        // Only fields the format actually uses can make it illegal; in I-format rc is immediate.
        cls = base_cls;
        case (base_cls)
            CLS_R:            if (!(reg_ok(ra) && reg_ok(rb) && reg_ok(rc))) cls = CLS_ILLEGAL;
            CLS_I, CLS_UNARY: if (!(reg_ok(ra) && reg_ok(rb)))               cls = CLS_ILLEGAL;
            default: ;
        endcase
        if (cls == CLS_ILLEGAL) alu_op = ALU_NONE;
    end

    assign ra_oh = NUM_REGS'(1) << ra;
    assign rb_oh = NUM_REGS'(1) << rb;
    assign rc_oh = NUM_REGS'(1) << rc;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, execute T3-T5 for ALU instructions.
// 6 cycles per ALU instruction, 4 per nop, no bubble between instructions.
// Waits in T1 while mem_ready is low; run is sampled only at instruction boundaries.
module control_sequencer
    import control_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16,
    parameter int REG_SEL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  run,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] ir,
    output logic [NUM_REGS-1:0]   gpr_in,
    output logic [NUM_REGS-1:0]   gpr_out,
    output logic                  pc_out,
    output logic                  pc_in,
    output logic                  inc_pc,
    output logic                  mar_in,
    output logic                  mdr_in,
    output logic                  mdr_out,
    output logic                  read,
    output logic                  ir_in,
    output logic                  y_in,
    output logic                  z_in,
    output logic                  z_low_out,
    output logic                  c_sign_out,
    output logic [3:0]            alu_op,
    output logic                  instr_done,
    output logic                  halted,
    output logic                  illegal
);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic                illegal_q;
    instr_class_t        cls;
    logic [3:0]          dec_alu_op;
    logic [NUM_REGS-1:0] ra_oh;
    logic [NUM_REGS-1:0] rb_oh;
    logic [NUM_REGS-1:0] rc_oh;
    logic                exec_cls;

    instr_decoder #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_REGS     (NUM_REGS),
        .REG_SEL_WIDTH(REG_SEL_WIDTH)
    ) u_dec (
        .ir    (ir),
        .cls   (cls),
        .alu_op(dec_alu_op),
        .ra_oh (ra_oh),
        .rb_oh (rb_oh),
        .rc_oh (rc_oh)
    );

    assign exec_cls = (cls == CLS_R) || (cls == CLS_I) || (cls == CLS_UNARY);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (run) state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   if (mem_ready) state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                if (cls == CLS_NOP)  state_nxt = run ? S_T0 : S_IDLE;
                else if (exec_cls)   state_nxt = S_T4;
                else                 state_nxt = S_HALT;
            end
            S_T4:   state_nxt = S_T5;
            S_T5:   state_nxt = run ? S_T0 : S_IDLE;
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_T3 && cls == CLS_ILLEGAL) illegal_q <= 1'b1;
        end
    end

    assign halted  = (state == S_HALT);
    assign illegal = illegal_q;

    always_comb begin
        gpr_in     = '0;
        gpr_out    = '0;
        pc_out     = 1'b0;
        pc_in      = 1'b0;
        inc_pc     = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        read       = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        z_low_out  = 1'b0;
        c_sign_out = 1'b0;
        alu_op     = ALU_NONE;
        instr_done = 1'b0;
        case (state)
            S_T0: begin
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; alu_op = ALU_ADD;
            end
            S_T1: begin
                z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1; ir_in = 1'b1;
            end
            S_T3: begin
                if (cls == CLS_NOP) begin
                    instr_done = 1'b1;
                end else if (exec_cls) begin
                    gpr_out = rb_oh; y_in = 1'b1;
                end
            end
            S_T4: begin
                alu_op = dec_alu_op;
                z_in   = 1'b1;
                case (cls)
                    CLS_R:   gpr_out    = rc_oh;
                    CLS_I:   c_sign_out = 1'b1;
                    default: gpr_out    = rb_oh;
                endcase
            end
            S_T5: begin
                z_low_out = 1'b1; gpr_in = ra_oh; instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench: behavioural datapath driven by the sequencer, directed scenarios plus a
// random program checked against an instruction-level reference interpreter.
module tb_control_sequencer;
    import control_pkg::*;

    localparam int NR = 12;

    logic          clk;
    logic          clear;
    logic          run;
    logic          mem_ready;
    logic [31:0]   tb_ir;
    logic [NR-1:0] gpr_in;
    logic [NR-1:0] gpr_out;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in;
    logic y_in, z_in, z_low_out, c_sign_out, instr_done, halted, illegal;
    logic [3:0]    alu_op;

    control_sequencer #(.DATA_WIDTH(32), .NUM_REGS(NR), .REG_SEL_WIDTH(4)) dut (
        .clk(clk), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(tb_ir),
        .gpr_in(gpr_in), .gpr_out(gpr_out), .pc_out(pc_out), .pc_in(pc_in),
        .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
        .read(read), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .z_low_out(z_low_out),
        .c_sign_out(c_sign_out), .alu_op(alu_op), .instr_done(instr_done),
        .halted(halted), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural datapath
    logic [31:0] regs [NR];
    logic [31:0] pre_regs [NR];
    logic [31:0] mem [64];
    logic [31:0] pc, mar, mdr, y, z, bus, alu_res, pre_pc;
    logic        do_preload;

    always_comb begin
        bus = '0;
        if (pc_out)     bus = pc;
        if (z_low_out)  bus = z;
        if (mdr_out)    bus = mdr;
        if (c_sign_out) bus = {{13{tb_ir[18]}}, tb_ir[18:0]};
        for (int i = 0; i < NR; i++) if (gpr_out[i]) bus = regs[i];
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = inc_pc ? bus + 32'd1 : y + bus;
            ALU_SUB: alu_res = y - bus;
            ALU_SHR: alu_res = y >> bus[4:0];
            ALU_SHL: alu_res = y << bus[4:0];
            ALU_ROR: alu_res = (y >> bus[4:0]) | (y << (6'd32 - {1'b0, bus[4:0]}));
            ALU_ROL: alu_res = (y << bus[4:0]) | (y >> (6'd32 - {1'b0, bus[4:0]}));
            ALU_AND: alu_res = y & bus;
            ALU_OR:  alu_res = y | bus;
            ALU_NEG: alu_res = -bus;
            ALU_NOT: alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < NR; i++) regs[i] <= pre_regs[i];
            pc    <= pre_pc;
            tb_ir <= '0;
        end else begin
            if (mar_in) mar <= bus;
            if (pc_in)  pc  <= bus;
            if (mdr_in && read && mem_ready) mdr <= mem[mar[5:0]];
            if (ir_in)  tb_ir <= bus;
            if (y_in)   y <= bus;
            if (z_in)   z <= alu_res;
            for (int i = 0; i < NR; i++) if (gpr_in[i]) regs[i] <= bus;
        end
    end

    logic [40:0] ctl_all;
    assign ctl_all = {gpr_in, gpr_out, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
                      read, ir_in, y_in, z_in, z_low_out, c_sign_out, alu_op, instr_done};

    int checks;
    int failures;
    int wait_left;
    logic [NR-1:0] tr_gin  [48];
    logic [NR-1:0] tr_gout [48];
    logic          tr_csign[48];
    logic          tr_read [48];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (read && wait_left > 0) begin
            mem_ready = 1'b0;
            wait_left--;
        end else begin
            mem_ready = 1'b1;
        end
        chk("gpr_in_onehot",  64'($onehot0(gpr_in)), 64'd1);
        chk("gpr_out_onehot", 64'($onehot0(gpr_out)), 64'd1);
        chk("alu_op_only_with_z", 64'((alu_op != 4'd0) && !z_in), 64'd0);
        if (halted) chk("halt_quiet", 64'(ctl_all), 64'd0);
    endtask

    task automatic do_reset();
        clear = 1'b1; run = 1'b0; do_preload = 1'b1;
        step(); step();
        clear = 1'b0; do_preload = 1'b0;
        step();
    endtask

    // Runs one instruction starting at the next cycle; stops on instr_done or halt.
    task automatic run_until_done(input int waits, input bit keep_run,
                                  output int cyc, output int dn);
        bit fin;
        fin = 1'b0; cyc = 0; dn = 0;
        run = 1'b1;
        wait_left = waits;
        for (int i = 0; i < 40; i++) begin
            step();
            tr_gin[cyc] = gpr_in; tr_gout[cyc] = gpr_out;
            tr_csign[cyc] = c_sign_out; tr_read[cyc] = read;
            cyc++;
            if (instr_done) begin
                dn++; run = keep_run; fin = 1'b1;
                break;
            end
            if (halted) begin
                fin = 1'b1;
                break;
            end
        end
        chk("instr_bounded", 64'(fin), 64'd1);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] op, input int ra, input int rb, input int rc);
        return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input int ra, input int rb, input logic [18:0] imm);
        return {op, 4'(ra), 4'(rb), imm};
    endfunction

    // Instruction-level reference semantics: dst = f(R[rb], operand)
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] b, input logic [31:0] c);
        logic [31:0] r;
        r = b;
        case (op)
            OP_ADD, OP_ADDI: r = b + c;
            OP_SUB:          r = b - c;
            OP_SHR:          r = b >> c[4:0];
            OP_SHL:          r = b << c[4:0];
            OP_ROR:          for (int k = 0; k < int'(c[4:0]); k++) r = {r[0], r[31:1]};
            OP_ROL:          for (int k = 0; k < int'(c[4:0]); k++) r = {r[30:0], r[31]};
            OP_AND, OP_ANDI: r = b & c;
            OP_OR, OP_ORI:   r = b | c;
            OP_NEG:          r = 32'd0 - b;
            OP_NOT:          r = ~b;
            default:         r = b;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] pick_op(input int k);
        case (k)
            0: return OP_ADD;   1: return OP_SUB;   2: return OP_SHR;   3: return OP_SHL;
            4: return OP_ROR;   5: return OP_ROL;   6: return OP_AND;   7: return OP_OR;
            8: return OP_ADDI;  9: return OP_ANDI; 10: return OP_ORI;  11: return OP_NEG;
            12: return OP_NOT;
            default: return OP_NOP;
        endcase
    endfunction

    initial begin
        int cyc, dn, nreads, done_at, w, exp_cyc;
        int ra, rb, rc;
        logic [4:0]  op;
        logic [18:0] imm;
        logic [31:0] mregs [NR];
        logic [4:0]  prog_op [16];
        bit          is_i;

        checks = 0; failures = 0; wait_left = 0;
        clear = 1'b1; run = 1'b0; mem_ready = 1'b1; do_preload = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        for (int i = 0; i < NR; i++) pre_regs[i] = 32'd0;
        pre_regs[2] = 32'h22; pre_regs[4] = 32'h24; pre_regs[5] = 32'h55;
        pre_pc = 32'd0;

        // Reset and idle
        mem[0] = 32'h4A920000;
        do_reset();
        chk("reset_outputs", 64'(ctl_all), 64'd0);
        chk("reset_halted",  64'(halted), 64'd0);
        chk("reset_illegal", 64'(illegal), 64'd0);
        step(); step();
        chk("idle_outputs", 64'(ctl_all), 64'd0);

        // and R5, R2, R4
        run_until_done(0, 1'b0, cyc, dn);
        chk("and_cycles", 64'(cyc), 64'd6);
        chk("and_done", 64'(dn), 64'd1);
        chk("and_t3_gpr_out", 64'(tr_gout[3]), 64'h4);
        chk("and_t4_gpr_out", 64'(tr_gout[4]), 64'h10);
        chk("and_t5_gpr_in",  64'(tr_gin[5]),  64'h20);
        step();
        chk("and_r5", 64'(regs[5]), 64'h20);
        chk("and_idle_after", 64'(ctl_all), 64'd0);

        // Same with three memory wait cycles
        do_reset();
        run_until_done(3, 1'b0, cyc, dn);
        nreads = 0;
        for (int i = 0; i < cyc; i++) if (tr_read[i]) nreads++;
        chk("wait_cycles", 64'(cyc), 64'd9);
        chk("wait_t1_reads", 64'(nreads), 64'd4);
        chk("wait_t5_gpr_in", 64'(tr_gin[8]), 64'h20);
        step();
        chk("wait_r5", 64'(regs[5]), 64'h20);

        // run dropped during T0: instruction still completes, then idle
        do_reset();
        run = 1'b1; step(); run = 1'b0;
        dn = 0; done_at = 0;
        for (int s = 0; s < 12; s++) begin
            step();
            if (instr_done) begin dn++; done_at = s + 2; end
        end
        chk("drop_run_done", 64'(dn), 64'd1);
        chk("drop_run_done_cycle", 64'(done_at), 64'd6);
        chk("drop_run_r5", 64'(regs[5]), 64'h20);
        chk("drop_run_idle", 64'(ctl_all), 64'd0);

        // Back-to-back add then addi
        mem[0] = enc_r(OP_ADD, 1, 2, 4);
        mem[1] = enc_i(OP_ADDI, 3, 1, 19'd5);
        do_reset();
        run_until_done(0, 1'b1, cyc, dn);
        chk("b2b_first_cycles", 64'(cyc), 64'd6);
        run_until_done(0, 1'b0, cyc, dn);
        chk("b2b_second_cycles", 64'(cyc), 64'd6);
        chk("b2b_t4_c_sign", 64'(tr_csign[4]), 64'd1);
        step();
        chk("b2b_r1", 64'(regs[1]), 64'h46);
        chk("b2b_r3", 64'(regs[3]), 64'h4B);

        // Illegal opcode 11111
        mem[0] = {5'b11111, 27'd0};
        do_reset();
        run_until_done(0, 1'b0, cyc, dn);
        chk("illop_cycles", 64'(cyc), 64'd5);
        chk("illop_done", 64'(dn), 64'd0);
        chk("illop_halted", 64'(halted), 64'd1);
        chk("illop_illegal", 64'(illegal), 64'd1);
        chk("illop_outputs", 64'(ctl_all), 64'd0);
        for (int s = 0; s < 6; s++) begin
            run = ~run;
            step();
        end
        chk("illop_sticky_halted", 64'(halted), 64'd1);
        chk("illop_sticky_outputs", 64'(ctl_all), 64'd0);
        do_reset();
        chk("clear_halted", 64'(halted), 64'd0);
        chk("clear_illegal", 64'(illegal), 64'd0);

        // Register number beyond NUM_REGS
        mem[0] = enc_r(OP_ADD, 13, 1, 2);
        do_reset();
        run_until_done(0, 1'b0, cyc, dn);
        chk("illreg_halted", 64'(halted), 64'd1);
        chk("illreg_illegal", 64'(illegal), 64'd1);

        // clear during T4, with run still high
        mem[0] = 32'h4A920000;
        do_reset();
        run = 1'b1;
        for (int s = 0; s < 5; s++) step();
        chk("t4_z_in", 64'(z_in), 64'd1);
        chk("t4_gpr_out", 64'(gpr_out), 64'h10);
        clear = 1'b1;
        step();
        chk("clear_t4_outputs", 64'(ctl_all), 64'd0);
        clear = 1'b0; run = 1'b0;
        step(); step();
        chk("clear_t4_idle", 64'(ctl_all), 64'd0);
        chk("clear_t4_r5_kept", 64'(regs[5]), 64'h55);

        // nop then halt
        mem[0] = enc_r(OP_NOP, 0, 0, 0);
        mem[1] = enc_r(OP_HALT, 0, 0, 0);
        do_reset();
        run_until_done(0, 1'b1, cyc, dn);
        chk("nop_cycles", 64'(cyc), 64'd4);
        chk("nop_done", 64'(dn), 64'd1);
        run_until_done(1, 1'b0, cyc, dn);
        chk("halt_cycles", 64'(cyc), 64'd6);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_illegal", 64'(illegal), 64'd0);

        // Random program against the instruction-level interpreter
        for (int i = 0; i < NR; i++) begin
            pre_regs[i] = $urandom;
            mregs[i] = pre_regs[i];
        end
        for (int i = 0; i < 16; i++) begin
            op  = pick_op(int'($urandom_range(0, 13)));
            ra  = int'($urandom_range(0, NR - 1));
            rb  = int'($urandom_range(0, NR - 1));
            is_i = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
            rc  = (op == OP_NEG || op == OP_NOT || op == OP_NOP) ? int'($urandom_range(0, 15))
                                                                 : int'($urandom_range(0, NR - 1));
            imm = 19'($urandom);
            mem[i] = is_i ? enc_i(op, ra, rb, imm) : enc_r(op, ra, rb, rc);
            prog_op[i] = op;
            if (op != OP_NOP)
                mregs[ra] = ref_alu(op, mregs[rb],
                                    is_i ? {{13{imm[18]}}, imm} : mregs[rc]);
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            w = int'($urandom_range(0, 3));
            run_until_done(w, (i < 15), cyc, dn);
            exp_cyc = 3 + w + ((prog_op[i] == OP_NOP) ? 1 : 3);
            chk($sformatf("rand_cycles_%0d", i), 64'(cyc), 64'(exp_cyc));
            chk($sformatf("rand_done_%0d", i), 64'(dn), 64'd1);
        end
        step();
        chk("rand_illegal", 64'(illegal), 64'd0);
        for (int i = 0; i < NR; i++)
            chk($sformatf("rand_reg_%0d", i), 64'(regs[i]), 64'(mregs[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised hardwired control unit for the datapath that replaces hand-driven control-signal sequencing. Steps through fetch (T0–T2) and execute (T3–T5) for register-register, immediate and unary ALU instructions. Decodes the instruction register, waits on memory, and drives one-hot GPR in/out selects and all bus/latch enables. It halts cleanly on `halt` or on an illegal opcode.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bus and IR width.
- `NUM_REGS`, 16: GPR count; width of `gpr_in` and `gpr_out`.
- `REG_SEL_WIDTH`, 4: width of the IR register fields; `2**REG_SEL_WIDTH` must be at least `NUM_REGS`.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `clear` in 1: synchronous, active-high reset.
- `run` in 1: level. While high, the sequencer fetches and executes continuously.
- `mem_ready` in 1: memory data valid; sampled in T1.
- `ir` in DATA_WIDTH: IR contents from the datapath.
- `gpr_in` out NUM_REGS: one-hot register load enable.
- `gpr_out` out NUM_REGS: one-hot register bus drive.
- `pc_out`, `pc_in`, `inc_pc`, `mar_in`, `mdr_in`, `mdr_out`, `read`, `ir_in`, `y_in`, `z_in`, `z_low_out`, `c_sign_out` out 1 each: datapath enables.
- `alu_op` out 4: ALU operation select; encoding in package.
- `instr_done` out 1: high during the final state of each instruction.
- `halted` out 1; `illegal` out 1: sticky status.

## Operation
- IR fields: opcode = `ir[31:27]`, ra = `ir[26:23]`, rb = `ir[22:19]`, rc = `ir[18:15]`. Register numbers at or above `NUM_REGS` are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. The state is a register; all outputs are a Moore decode of state and `ir`, and are zero in IDLE and HALT.
- **IDLE:**
  - `run` = 1 → T0; otherwise stay in IDLE.
- **T0:**
  - Asserted: `pc_out`, `mar_in`, `inc_pc`, `z_in`.
  - → T1.
- **T1:**
  - Asserted: `z_low_out`, `pc_in`, `read`, `mdr_in`.
  - `mem_ready` = 0 → stay in T1 with `read`/`mdr_in` held. `pc_in` is held as well, which is harmless because Z is unchanged.
  - `mem_ready` = 1 → T2.
- **T2:**
  - Asserted: `mdr_out`, `ir_in`.
  - → T3.
- **T3 (decode on the updated `ir`):**
  - `nop` → completes here: `instr_done` = 1, then → T0 if `run` = 1, else → IDLE.
  - `halt` → HALT.
  - Illegal opcode or register → HALT with `illegal` set.
  - Otherwise: `gpr_out[rb]`, `y_in` → T4.
- **T4:**
  - R-format: `gpr_out[rc]`, `alu_op`, `z_in`.
  - I-format: `c_sign_out`, `alu_op`, `z_in`.
  - Unary (`neg`, `not`): `gpr_out[rb]`, `alu_op`, `z_in`. The ALU ignores Y.
  - → T5.
- **T5:**
  - Asserted: `z_low_out`, `gpr_in[ra]`, `instr_done`.
  - → T0 if `run` = 1, else → IDLE.
- **HALT:**
  - Absorbing; only `clear` exits.
  - `halted` = 1, and `illegal` is set when an illegal opcode or register caused the halt.
- Supported opcodes: `add`, `sub`, `shr`, `shl`, `ror`, `rol`, `and`, `or`, `addi`, `andi`, `ori`, `neg`, `not`, `nop`, `halt`. All others (`ld`, `st`, `mul`, `div`, branches, I/O) are illegal in this generation.
- `alu_op` is zero except in T0 (ADD, used for the PC increment; `inc_pc` is also asserted) and in T4.
- One-hot selects: at most one bit of `gpr_in` and of `gpr_out` is ever high.

## Timing
- `clear` high at a rising edge → next state IDLE. `halted` and `illegal` reset to 0, and every output is 0 from that edge onward. This holds from any state, including mid-instruction and mid-T1 wait.
- Fetch takes 3 cycles plus the number of T1 cycles with `mem_ready` = 0.
- Full ALU instruction: 6 cycles when `mem_ready` = 1. `nop`: 4 cycles. Back-to-back instructions have no bubble.
- Outputs are stable for the whole state. Datapath registers capture on the rising edge that ends the state.
- `run` is sampled only in IDLE, T3 (`nop`) and T5. Dropping it mid-instruction finishes the current instruction.
- `clear` and `run` high together: `clear` wins.

## Structure
- Package `control_pkg`: opcode localparams (5-bit: `add` 00011, `sub` 00100, `shr` 00101, `shl` 00110, `ror` 00111, `rol` 01000, `and` 01001, `or` 01010, `addi` 01011, `andi` 01100, `ori` 01101, `neg` 10000, `not` 10001, `nop` 11010, `halt` 11011). It also holds the `alu_op` encodings and the state encoding.
- Sub-module `instr_decoder` (combinational): takes `ir` and produces opcode class (R, I, unary, nop, halt, illegal), `alu_op`, and decoded `ra`/`rb`/`rc` one-hot vectors.

## Test plan
- Preload R2 = 0x22 and R4 = 0x24, `ir` fetch 0x4A920000 (`and R5, R2, R4`) with `mem_ready` = 1 → 6 cycles, `gpr_out` = bit 2 in T3 and bit 4 in T4, `gpr_in` = bit 5 in T5, R5 = 0x20, `instr_done` pulses once.
- Same instruction with `mem_ready` low for 3 cycles → T1 held for 4 cycles with `read` = 1 throughout; total 9 cycles; same result.
- Back-to-back `add R1, R2, R4` then `addi R3, R1, 5` → second T0 directly follows first T5; `c_sign_out` = 1 in second T4; R1 = 0x46, R3 = 0x4B.
- Opcode 11111 fetched → HALT after T3; `halted` = 1, `illegal` = 1, all enables 0; `run` toggling has no effect until `clear`.
- `clear` asserted during T4 → next cycle IDLE, all outputs 0; destination register not written.
- `nop` then `halt` → `nop` completes in 4 cycles; `halt` → `halted` = 1, `illegal` = 0.
